// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine programme sequencer.
//   phase_e     : state / phase code published on the phase output
//   *_dur       : phase durations in seconds for a given water level
//   worst_total : longest possible programme, used to size the time counters
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } phase_e;

    function automatic int unsigned wash_dur(input int unsigned base, input logic [2:0] water);
        return base + 32'(water);
    endfunction

    // Rinse spends water+3 s draining and water s filling, hence the 2x.
    function automatic int unsigned rinse_dur(input int unsigned base, input logic [2:0] water);
        return base + 32'(water) * 2;
    endfunction

    function automatic int unsigned spin_dur(input int unsigned base, input logic [2:0] water);
        return base + 32'(water);
    endfunction

    function automatic int unsigned worst_total(input int unsigned wash_base,
                                                input int unsigned rinse_base,
                                                input int unsigned spin_base,
                                                input int unsigned rinse_max);
        return wash_dur(wash_base, 3'd7) + rinse_max * rinse_dur(rinse_base, 3'd7)
             + spin_dur(spin_base, 3'd7);
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_prescaler.sv
// One-second tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (running and not paused)
//   clr        : synchronous clear, wins over en
//   tick       : high on the enabled cycle where the count sits at TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    // Gating with en means a pause landing on the terminal count swallows
    // that tick; it fires on the first unpaused cycle instead.
    assign tick = en && (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer: optional start delay, then the enabled
// wash / rinse (repeated) / spin phases, timed in whole seconds.
//   inputs : clk, rst_n, power, start, pause, mode_mask, rinse_cnt, water, delay_s
//   outputs: phase, rinse_idx, phase_time, total_time, delay_left (all registered),
//            in_water / out_water (decoded from registers), busy, done, done_pulse
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned TW         = 8,
    parameter int unsigned RINSE_MAX  = 3,
    parameter int unsigned DW         = 7,
    parameter int unsigned WASH_BASE  = 9,
    parameter int unsigned RINSE_BASE = 9,
    parameter int unsigned SPIN_BASE  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          power,
    input  logic          start,
    input  logic          pause,
    input  logic [2:0]    mode_mask,
    input  logic [1:0]    rinse_cnt,
    input  logic [2:0]    water,
    input  logic [DW-1:0] delay_s,
    output logic [2:0]    phase,
    output logic [1:0]    rinse_idx,
    output logic [TW-1:0] phase_time,
    output logic [TW-1:0] total_time,
    output logic [DW-1:0] delay_left,
    output logic          in_water,
    output logic          out_water,
    output logic          busy,
    output logic          done,
    output logic          done_pulse
);
    localparam int unsigned WORST_TOTAL = worst_total(WASH_BASE, RINSE_BASE, SPIN_BASE, RINSE_MAX);
    localparam longint unsigned TW_LIMIT = (64'd1 << TW) - 64'd1;

    if (64'(WORST_TOTAL) > TW_LIMIT) begin : g_tw_too_narrow
        $error("wash_sequencer: TW cannot hold the worst-case programme total");
    end

    function automatic logic [TW-1:0] dur_of(input phase_e ph, input logic [2:0] w);
        logic [TW-1:0] d;
        case (ph)
            WASH:    d = TW'(wash_dur(WASH_BASE, w));
            RINSE:   d = TW'(rinse_dur(RINSE_BASE, w));
            SPIN:    d = TW'(spin_dur(SPIN_BASE, w));
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic phase_e first_phase(input logic [2:0] mask);
        return mask[0] ? WASH : mask[1] ? RINSE : mask[2] ? SPIN : DONE;
    endfunction

    // Phase following cur; more_rinse says another rinse repetition is due.
    function automatic phase_e next_phase(input phase_e cur, input logic [2:0] mask,
                                          input logic more_rinse);
        phase_e n;
        case (cur)
            WASH:    n = mask[1] ? RINSE : mask[2] ? SPIN : DONE;
            RINSE:   n = more_rinse ? RINSE : mask[2] ? SPIN : DONE;
            default: n = DONE;
        endcase
        return n;
    endfunction

    function automatic logic [TW-1:0] plan_total(input logic [2:0] mask, input logic [1:0] r,
                                                 input logic [2:0] w);
        logic [TW-1:0] t;
        t = '0;
        if (mask[0]) t = t + dur_of(WASH, w);
        if (mask[1]) t = t + TW'(r) * dur_of(RINSE, w);
        if (mask[2]) t = t + dur_of(SPIN, w);
        return t;
    endfunction

    // Zero rinses still means one; anything above RINSE_MAX is capped.
    function automatic logic [1:0] clamp_rinses(input logic [1:0] rc);
        logic [1:0] r;
        if (rc == 2'd0)                 r = 2'd1;
        else if (32'(rc) > RINSE_MAX)   r = 2'(RINSE_MAX);
        else                            r = rc;
        return r;
    endfunction

    phase_e        state_reg, state_next, adv_state;
    logic [TW-1:0] phase_time_reg, phase_time_next, total_time_reg, total_time_next;
    logic [DW-1:0] delay_left_reg, delay_left_next, delay_reg, delay_next;
    logic [1:0]    rinse_idx_reg, rinse_idx_next, rinses_reg, rinses_next, live_rinses;
    logic [2:0]    mask_reg, mask_next, water_reg, water_next;
    logic          done_pulse_reg, done_pulse_next;
    logic [TW-1:0] preview_phase, preview_total, elapsed, water_tw;
    logic          tick;

    assign live_rinses   = clamp_rinses(rinse_cnt);
    assign preview_phase = dur_of(first_phase(mode_mask), water);
    assign preview_total = plan_total(mode_mask, live_rinses, water);

    assign busy = (state_reg == DELAY) || (state_reg == WASH) ||
                  (state_reg == RINSE) || (state_reg == SPIN);

    // The prescaler only runs while a programme is live; being idle or done
    // keeps it cleared so an accepted start always begins from count 0.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (power && busy && !pause),
        .clr   (!power || !busy),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            phase_time_reg <= '0;
            total_time_reg <= '0;
            delay_left_reg <= '0;
            rinse_idx_reg  <= '0;
            done_pulse_reg <= 1'b0;
            mask_reg       <= '0;
            rinses_reg     <= '0;
            water_reg      <= '0;
            delay_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            phase_time_reg <= phase_time_next;
            total_time_reg <= total_time_next;
            delay_left_reg <= delay_left_next;
            rinse_idx_reg  <= rinse_idx_next;
            done_pulse_reg <= done_pulse_next;
            mask_reg       <= mask_next;
            rinses_reg     <= rinses_next;
            water_reg      <= water_next;
            delay_reg      <= delay_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_time_next = phase_time_reg;
        total_time_next = total_time_reg;
        delay_left_next = delay_left_reg;
        rinse_idx_next  = rinse_idx_reg;
        done_pulse_next = 1'b0;
        mask_next       = mask_reg;
        rinses_next     = rinses_reg;
        water_next      = water_reg;
        delay_next      = delay_reg;
        adv_state       = DONE;

        if (!power || state_reg == IDLE) begin
            // Idle (or powered off): keep the display preview tracking inputs.
            state_next      = IDLE;
            phase_time_next = preview_phase;
            total_time_next = preview_total;
            delay_left_next = delay_s;
            rinse_idx_next  = '0;
            if (power && start && mode_mask != 3'b000) begin
                mask_next   = mode_mask;
                rinses_next = live_rinses;
                water_next  = water;
                delay_next  = delay_s;
                state_next  = (delay_s != '0) ? DELAY : first_phase(mode_mask);
            end
        end else begin
            case (state_reg)
                DONE: begin
                    if (start) begin
                        state_next      = (delay_reg != '0) ? DELAY : first_phase(mask_reg);
                        phase_time_next = dur_of(first_phase(mask_reg), water_reg);
                        total_time_next = plan_total(mask_reg, rinses_reg, water_reg);
                        delay_left_next = delay_reg;
                        rinse_idx_next  = '0;
                    end
                end
                DELAY: begin
                    if (tick) begin
                        delay_left_next = delay_left_reg - 1'b1;
                        if (delay_left_reg == DW'(1)) state_next = first_phase(mask_reg);
                    end
                end
                WASH, RINSE, SPIN: begin
                    if (tick) begin
                        total_time_next = total_time_reg - 1'b1;
                        if (phase_time_reg == TW'(1)) begin
                            adv_state = next_phase(state_reg, mask_reg,
                                                   (rinse_idx_reg + 2'd1) < rinses_reg);
                            state_next = adv_state;
                            if (state_reg == RINSE && adv_state == RINSE)
                                rinse_idx_next = rinse_idx_reg + 2'd1;
                            if (adv_state == DONE) begin
                                phase_time_next = '0;
                                total_time_next = '0;
                                done_pulse_next = 1'b1;
                            end else begin
                                phase_time_next = dur_of(adv_state, water_reg);
                            end
                        end else begin
                            phase_time_next = phase_time_reg - 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Seconds already spent in the current phase drive the valve schedule.
    assign water_tw = TW'(water_reg);
    assign elapsed  = dur_of(state_reg, water_reg) - phase_time_reg;

    always_comb begin
        in_water  = 1'b0;
        out_water = 1'b0;
        if (power) begin
            case (state_reg)
                WASH:  in_water = (elapsed < water_tw);
                RINSE: begin
                    if (elapsed < water_tw + TW'(3))
                        out_water = 1'b1;
                    else if (elapsed < (water_tw << 1) + TW'(3))
                        in_water = 1'b1;
                end
                SPIN:  out_water = 1'b1;
                default: ;
            endcase
        end
    end

    assign phase      = state_reg;
    assign rinse_idx  = rinse_idx_reg;
    assign phase_time = phase_time_reg;
    assign total_time = total_time_reg;
    assign delay_left = delay_left_reg;
    assign done       = (state_reg == DONE);
    assign done_pulse = done_pulse_reg;
endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with TICK_DIV=4. A programme is
// modelled as a list of (phase, duration, rinse number) segments plus a
// second counter; expected outputs are derived from that list each cycle.
module tb_wash_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n, power, start, pause;
    logic [2:0] mode_mask, water;
    logic [1:0] rinse_cnt;
    logic [6:0] delay_s;
    logic [2:0] phase;
    logic [1:0] rinse_idx;
    logic [7:0] phase_time, total_time;
    logic [6:0] delay_left;
    logic       in_water, out_water, busy, done, done_pulse;

    always #5 clk = ~clk;

    wash_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .start(start), .pause(pause),
        .mode_mask(mode_mask), .rinse_cnt(rinse_cnt), .water(water), .delay_s(delay_s),
        .phase(phase), .rinse_idx(rinse_idx), .phase_time(phase_time),
        .total_time(total_time), .delay_left(delay_left), .in_water(in_water),
        .out_water(out_water), .busy(busy), .done(done), .done_pulse(done_pulse)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    // Reference model state
    int seg_ph[0:7], seg_dur[0:7], seg_ridx[0:7], nseg;
    int m_kind;                          // 0 idle, 1 delay, 2 running, 3 done
    int m_seg, m_sec, m_cyc, m_dleft, m_pulse;
    int m_prev_pt, m_prev_tt, m_prev_dl;
    int c_mask, c_rc, c_water, c_delay;
    int t_in, t_out, t_rinse, t_delay, t_maxri;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build(input int mask, input int rc, input int w);
        int eff;
        eff  = (rc == 0) ? 1 : ((rc > 3) ? 3 : rc);
        nseg = 0;
        if ((mask & 1) != 0) begin
            seg_ph[nseg] = 2; seg_dur[nseg] = 9 + w; seg_ridx[nseg] = 0; nseg++;
        end
        if ((mask & 2) != 0) begin
            for (int i = 0; i < eff; i++) begin
                seg_ph[nseg] = 3; seg_dur[nseg] = 9 + 2 * w; seg_ridx[nseg] = i; nseg++;
            end
        end
        if ((mask & 4) != 0) begin
            seg_ph[nseg] = 4; seg_dur[nseg] = 3 + w;
            seg_ridx[nseg] = ((mask & 2) != 0) ? eff - 1 : 0; nseg++;
        end
    endtask

    function automatic int sum_from(input int s);
        int t = 0;
        for (int j = s; j < nseg; j++) t += seg_dur[j];
        return t;
    endfunction

    task automatic model_reset();
        m_kind = 0; m_seg = 0; m_sec = 0; m_cyc = 0; m_dleft = 0; m_pulse = 0;
        m_prev_pt = 0; m_prev_tt = 0; m_prev_dl = 0; nseg = 0;
        c_mask = 0; c_rc = 0; c_water = 0; c_delay = 0;
    endtask

    task automatic preview();
        build(int'(mode_mask), int'(rinse_cnt), int'(water));
        m_prev_pt = (nseg > 0) ? seg_dur[0] : 0;
        m_prev_tt = sum_from(0);
        m_prev_dl = int'(delay_s);
    endtask

    task automatic begin_run();
        m_cyc = 0;
        if (c_delay > 0) begin
            m_kind = 1; m_dleft = c_delay;
        end else begin
            m_kind = 2; m_seg = 0; m_sec = 0;
        end
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (!power) begin
            m_kind = 0;
            preview();
            return;
        end
        case (m_kind)
            0: begin
                preview();
                if (start && mode_mask != 3'd0) begin
                    c_mask = int'(mode_mask); c_rc = int'(rinse_cnt);
                    c_water = int'(water); c_delay = int'(delay_s);
                    begin_run();
                end
            end
            1: if (!pause) begin
                if (m_cyc == TD - 1) begin
                    m_cyc = 0; m_dleft--;
                    if (m_dleft == 0) begin m_kind = 2; m_seg = 0; m_sec = 0; end
                end else m_cyc++;
            end
            2: if (!pause) begin
                if (m_cyc == TD - 1) begin
                    m_cyc = 0; m_sec++;
                    if (m_sec == seg_dur[m_seg]) begin
                        m_seg++; m_sec = 0;
                        if (m_seg == nseg) begin m_kind = 3; m_pulse = 1; end
                    end
                end else m_cyc++;
            end
            default: if (start) begin
                build(c_mask, c_rc, c_water);
                begin_run();
            end
        endcase
    endtask

    task automatic compare();
        int e_ph, e_ri, e_pt, e_tt, e_dl, e_in, e_out, e_busy, e_done, w, e;
        e_ph = 0; e_ri = 0; e_pt = 0; e_tt = 0; e_dl = 0;
        e_in = 0; e_out = 0; e_busy = 0; e_done = 0;
        case (m_kind)
            0: begin e_pt = m_prev_pt; e_tt = m_prev_tt; e_dl = m_prev_dl; end
            1: begin
                e_ph = 1; e_pt = seg_dur[0]; e_tt = sum_from(0); e_dl = m_dleft; e_busy = 1;
            end
            2: begin
                e_ph = seg_ph[m_seg]; e_ri = seg_ridx[m_seg]; e_busy = 1;
                e_pt = seg_dur[m_seg] - m_sec; e_tt = sum_from(m_seg) - m_sec;
                w = c_water; e = m_sec;
                if (e_ph == 2) e_in = int'(e < w);
                if (e_ph == 3) begin
                    e_out = int'(e < w + 3);
                    e_in  = int'(e >= w + 3 && e < 2 * w + 3);
                end
                if (e_ph == 4) e_out = 1;
                if (!power) begin e_in = 0; e_out = 0; end
            end
            default: begin e_ph = 5; e_ri = seg_ridx[nseg - 1]; e_done = 1; end
        endcase
        chk("phase", int'(phase), e_ph);
        chk("rinse_idx", int'(rinse_idx), e_ri);
        chk("phase_time", int'(phase_time), e_pt);
        chk("total_time", int'(total_time), e_tt);
        chk("delay_left", int'(delay_left), e_dl);
        chk("in_water", int'(in_water), e_in);
        chk("out_water", int'(out_water), e_out);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("done_pulse", int'(done_pulse), m_pulse);
        chk("valve_exclusive", int'(in_water && out_water), 0);
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
        compare();
        if (phase == 3'd1) t_delay++;
        if (phase == 3'd3) t_rinse++;
        if (in_water) t_in++;
        if (out_water) t_out++;
        if (int'(rinse_idx) > t_maxri) t_maxri = int'(rinse_idx);
    endtask

    task automatic clear_tally();
        t_in = 0; t_out = 0; t_rinse = 0; t_delay = 0; t_maxri = 0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit got = 0;
        lat = 0;
        while (lat < budget && !got) begin
            step();
            lat++;
            if (done_pulse) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: no done_pulse after %0d cycles, required within %0d", lat, budget);
        end
    endtask

    // Accept edge counts as cycle 0 of the latency.
    task automatic run_prog(output int lat);
        clear_tally();
        start = 1'b1; step(); start = 1'b0;
        wait_done(600, lat);
    endtask

    task automatic power_cycle();
        power = 1'b0; step(); power = 1'b1; step();
    endtask

    int lat, guard;

    initial begin
        rst_n = 1'b0; power = 1'b1; start = 1'b0; pause = 1'b0;
        mode_mask = 3'd0; rinse_cnt = 2'd0; water = 3'd0; delay_s = 7'd0;
        clear_tally();
        model_reset();
        step(); step();
        chk("reset_phase", int'(phase), 0);
        chk("reset_total", int'(total_time), 0);
        rst_n = 1'b1;

        // Full programme, preview 11/42, done 168 cycles after start
        mode_mask = 3'b111; water = 3'd2; rinse_cnt = 2'd2; delay_s = 7'd0;
        step();
        chk("preview_phase_time", int'(phase_time), 11);
        chk("preview_total", int'(total_time), 42);
        run_prog(lat);
        chk("full_latency", lat, 168);
        chk("full_in_water_cycles", t_in, 24);
        chk("full_out_water_cycles", t_out, 60);
        chk("full_rinse_cycles", t_rinse, 104);
        step();
        chk("done_level_held", int'(done), 1);
        power_cycle();

        // Delay 3 s with rinse skipped
        mode_mask = 3'b101; delay_s = 7'd3;
        step();
        run_prog(lat);
        chk("delay_cycles", t_delay, 12);
        chk("delay_latency", lat, 76);
        chk("skip_rinse_cycles", t_rinse, 0);
        chk("skip_rinse_idx", t_maxri, 0);
        power_cycle();

        // Pause mid-WASH for 10 cycles
        mode_mask = 3'b111; delay_s = 7'd0;
        step();
        start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        chk("pre_pause_phase_time", int'(phase_time), 6);
        chk("pre_pause_total", int'(total_time), 37);
        pause = 1'b1;
        repeat (10) step();
        chk("paused_phase_time", int'(phase_time), 6);
        chk("paused_total", int'(total_time), 37);
        pause = 1'b0;
        wait_done(600, lat);
        chk("pause_latency", 30 + lat, 178);
        power_cycle();

        // Power drop mid-RINSE, then full re-run
        start = 1'b1; step(); start = 1'b0;
        repeat (59) step();
        chk("mid_rinse_phase", int'(phase), 3);
        power = 1'b0; step();
        chk("pdrop_phase", int'(phase), 0);
        chk("pdrop_valves", int'(in_water) + int'(out_water), 0);
        chk("pdrop_preview_pt", int'(phase_time), 11);
        chk("pdrop_preview_tt", int'(total_time), 42);
        power = 1'b1; step();
        run_prog(lat);
        chk("rerun_latency", lat, 168);
        power_cycle();

        // Empty mask start is ignored
        mode_mask = 3'b000; step();
        start = 1'b1; step(); start = 1'b0; step();
        chk("mask0_phase", int'(phase), 0);
        chk("mask0_busy", int'(busy), 0);

        // rinse_cnt=0 means one rinse
        mode_mask = 3'b111; rinse_cnt = 2'd0; step();
        chk("rc0_preview_total", int'(total_time), 29);
        run_prog(lat);
        chk("rc0_latency", lat, 116);
        chk("rc0_rinse_cycles", t_rinse, 52);
        power_cycle();

        // Asynchronous reset mid-SPIN
        start = 1'b1; step(); start = 1'b0;
        repeat (100) step();
        chk("pre_reset_phase", int'(phase), 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_phase", int'(phase), 0);
        chk("async_reset_pt", int'(phase_time), 0);
        chk("async_reset_valve", int'(out_water), 0);
        compare();
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_reset_preview", int'(total_time), 29);

        // Randomised programmes with pause, start spam, config churn, reruns
        for (int r = 0; r < 10; r++) begin
            mode_mask = 3'($urandom_range(1, 7));
            rinse_cnt = 2'($urandom_range(0, 3));
            water     = 3'($urandom_range(0, 7));
            delay_s   = 7'($urandom_range(0, 3));
            pause     = 1'b0;
            step();
            start = 1'b1; step(); start = 1'b0;
            for (int pass = 0; pass < 2; pass++) begin
                guard = 0;
                while (m_kind != 3 && m_kind != 0 && guard < 1500) begin
                    pause = ($urandom_range(0, 7) == 0);
                    start = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 15) == 0) begin
                        mode_mask = 3'($urandom); water = 3'($urandom);
                        rinse_cnt = 2'($urandom); delay_s = 7'($urandom_range(0, 5));
                    end
                    if (r == 9 && guard == 200) power = 1'b0;
                    step();
                    power = 1'b1;
                    guard++;
                end
                start = 1'b0; pause = 1'b0;
                if (guard >= 1500) begin
                    n_tests++; n_fail++;
                    $display("FAIL random_budget: run %0d still busy after %0d cycles, required fewer", r, guard);
                end
                if (pass == 0 && m_kind == 3) begin
                    step();
                    start = 1'b1; step(); start = 1'b0;
                end
            end
            power_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
